// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
// The state enum, requester IDs and default geometry live here.
package mem_port_arbiter_pkg;

    localparam int DEF_ADDR_WIDTH = 12;
    localparam int DEF_BYTE_SIZE  = 4;

    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_DM = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        RMW  = 1'b1
    } state_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, data and memory-side signals of the arbiter. The slave modport is
// the arbiter's view; master is the surrounding pipeline/memory view.
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = mem_port_arbiter_pkg::DEF_ADDR_WIDTH,
    parameter int BYTE_SIZE  = mem_port_arbiter_pkg::DEF_BYTE_SIZE
);
    localparam int DW = 8 * BYTE_SIZE;

    logic                  if_req;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic                  if_gnt;
    logic                  if_valid;
    logic [DW-1:0]         if_rdata;

    logic                  dm_req;
    logic                  dm_we;
    logic                  dm_byte;
    logic [ADDR_WIDTH-1:0] dm_addr;
    logic [DW-1:0]         dm_wdata;
    logic                  dm_gnt;
    logic                  dm_valid;
    logic [DW-1:0]         dm_rdata;

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DW-1:0]         mem_wd;
    logic [DW-1:0]         mem_rd;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_byte, dm_addr, dm_wdata, mem_rd,
        output if_gnt, if_valid, if_rdata, dm_gnt, dm_valid, dm_rdata,
               mem_we, mem_addr, mem_wd
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_byte, dm_addr, dm_wdata, mem_rd,
        input  if_gnt, if_valid, if_rdata, dm_gnt, dm_valid, dm_rdata,
               mem_we, mem_addr, mem_wd
    );

endinterface

// File: rtl/mem_port_arbiter_pick.sv
// Combinational grant selector: fixed data-over-fetch priority by default,
// round-robin on conflict when MEM_ARB_RR_EN is defined.
module mem_arb_pick
    import mem_port_arbiter_pkg::*;
(
    input  logic en_i,
    input  logic if_req_i,
    input  logic dm_req_i,
`ifdef MEM_ARB_RR_EN
    input  logic ptr_i,
`endif
    output logic if_gnt_o,
    output logic dm_gnt_o
);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        if_gnt_o = 1'b0;
        dm_gnt_o = 1'b0;
        if (en_i) begin
`ifdef MEM_ARB_RR_EN
            if (if_req_i && dm_req_i) begin
                dm_gnt_o = (ptr_i == REQ_DM);
                if_gnt_o = (ptr_i == REQ_IF);
            end else begin
                dm_gnt_o = dm_req_i;
                if_gnt_o = if_req_i;
            end
`else
            dm_gnt_o = dm_req_i;
            if_gnt_o = if_req_i && !dm_req_i;
`endif
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port arbiter/sequencer for the unified memory; byte stores run as a
// two-cycle read-modify-write. Define MEM_ARB_RR_EN for round-robin arbitration.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int BYTE_SIZE  = DEF_BYTE_SIZE
) (
    input  logic               clk,
    input  logic               reset,
    mem_port_arbiter_if.slave  bus,
    output logic               busy
);

    localparam int DW = 8 * BYTE_SIZE;

    state_e                state_q, state_d;
    logic                  arb_en;
    logic                  if_gnt, dm_gnt;
    logic                  byte_store;
    logic                  if_valid_q, dm_valid_q;
    logic [DW-1:0]         if_rdata_q, dm_rdata_q, merge_q;
    logic [ADDR_WIDTH-1:0] rmw_addr_q;
    logic [7:0]            rmw_byte_q;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DW-1:0]         mem_wd;

    // Reset gates the grants immediately, even while requests are held high.
    assign arb_en     = (state_q == IDLE) && !reset;
    assign byte_store = bus.dm_we && bus.dm_byte;

`ifdef MEM_ARB_RR_EN
    logic rr_ptr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)               rr_ptr_q <= REQ_DM;
        else if (if_gnt || dm_gnt) rr_ptr_q <= ~rr_ptr_q;
    end
`endif

    mem_arb_pick u_pick (
        .en_i     (arb_en),
        .if_req_i (bus.if_req),
        .dm_req_i (bus.dm_req),
`ifdef MEM_ARB_RR_EN
        .ptr_i    (rr_ptr_q),
`endif
        .if_gnt_o (if_gnt),
        .dm_gnt_o (dm_gnt)
    );

    always_comb begin
        state_d  = state_q;
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_wd   = '0;
        case (state_q)
            IDLE: begin
                if (if_gnt) begin
                    mem_addr = bus.if_addr;
                end else if (dm_gnt) begin
                    mem_addr = bus.dm_addr;
                    if (bus.dm_we && !bus.dm_byte) begin
                        mem_we = 1'b1;
                        mem_wd = bus.dm_wdata;
                    end
                    if (byte_store) state_d = RMW;
                end
            end
            RMW: begin
                mem_we   = 1'b1;
                mem_addr = rmw_addr_q;
                mem_wd   = {merge_q[DW-1:8], rmw_byte_q};
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            if_valid_q <= 1'b0;
            dm_valid_q <= 1'b0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
            merge_q    <= '0;
            rmw_addr_q <= '0;
            rmw_byte_q <= '0;
        end else begin
            state_q    <= state_d;
            if_valid_q <= if_gnt;
            dm_valid_q <= (dm_gnt && !byte_store) || (state_q == RMW);
            if (if_gnt) if_rdata_q <= bus.mem_rd;
            if (dm_gnt && !bus.dm_we) dm_rdata_q <= bus.mem_rd;
            if (dm_gnt && byte_store) begin
                merge_q    <= bus.mem_rd;
                rmw_addr_q <= bus.dm_addr;
                rmw_byte_q <= bus.dm_wdata[7:0];
            end
        end
    end

    assign bus.if_gnt   = if_gnt;
    assign bus.dm_gnt   = dm_gnt;
    assign bus.if_valid = if_valid_q;
    assign bus.dm_valid = dm_valid_q;
    assign bus.if_rdata = if_rdata_q;
    assign bus.dm_rdata = dm_rdata_q;
    assign bus.mem_we   = mem_we;
    assign bus.mem_addr = mem_addr;
    assign bus.mem_wd   = mem_wd;
    assign busy         = (state_q == RMW);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level memory/arbitration model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int AW    = DEF_ADDR_WIDTH;
    localparam int DW    = 8 * DEF_BYTE_SIZE;
    localparam int WORDS = 1 << (AW - 2);

    logic clk = 1'b0;
    logic reset;
    logic busy;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_WIDTH(AW), .BYTE_SIZE(DEF_BYTE_SIZE)) bus ();

    mem_port_arbiter #(.ADDR_WIDTH(AW), .BYTE_SIZE(DEF_BYTE_SIZE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .busy  (busy)
    );

    // Memory instance seen by the DUT: combinational read, clocked write.
    logic [DW-1:0] env_mem [WORDS];
    assign bus.mem_rd = env_mem[bus.mem_addr[AW-1:2]];
    always @(posedge clk) if (bus.mem_we) env_mem[bus.mem_addr[AW-1:2]] <= bus.mem_wd;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: memory contents, port occupancy and pending responses.
    logic [DW-1:0] m_mem [WORDS];
    logic          m_rmw, m_ptr, m_if_valid, m_dm_valid;
    logic [DW-1:0] m_if_rdata, m_dm_rdata, m_rmw_new;
    logic [AW-1:0] m_rmw_addr;
    logic          c_if_gnt = 1'b0, c_dm_gnt = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_rmw      <= 1'b0;
            m_ptr      <= 1'b1;
            m_if_valid <= 1'b0;
            m_dm_valid <= 1'b0;
            m_if_rdata <= '0;
            m_dm_rdata <= '0;
        end else begin
            m_if_valid <= c_if_gnt;
            m_dm_valid <= m_rmw || (c_dm_gnt && !(bus.dm_we && bus.dm_byte));
            if (m_rmw) begin
                m_mem[m_rmw_addr[AW-1:2]] <= m_rmw_new;
                m_rmw <= 1'b0;
            end
            if (c_if_gnt) m_if_rdata <= m_mem[bus.if_addr[AW-1:2]];
            if (c_dm_gnt) begin
                if (!bus.dm_we) m_dm_rdata <= m_mem[bus.dm_addr[AW-1:2]];
                else if (!bus.dm_byte) m_mem[bus.dm_addr[AW-1:2]] <= bus.dm_wdata;
                else begin
                    m_rmw      <= 1'b1;
                    m_rmw_addr <= bus.dm_addr;
                    m_rmw_new  <= {m_mem[bus.dm_addr[AW-1:2]][DW-1:8], bus.dm_wdata[7:0]};
                end
            end
            if (c_if_gnt || c_dm_gnt) m_ptr <= ~m_ptr;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        logic          free, win_dm, e_dm, e_if, e_we, wd_chk;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd;
        free = !m_rmw && !reset;
`ifdef MEM_ARB_RR_EN
        win_dm = m_ptr;
`else
        win_dm = 1'b1;
`endif
        e_dm   = free && bus.dm_req && (!bus.if_req || win_dm);
        e_if   = free && bus.if_req && !e_dm;
        e_we   = 1'b0;
        e_addr = '0;
        e_wd   = '0;
        wd_chk = 1'b1;
        if (m_rmw) begin
            e_we = 1'b1; e_addr = m_rmw_addr; e_wd = m_rmw_new;
        end else if (e_dm) begin
            e_addr = bus.dm_addr;
            e_we   = bus.dm_we && !bus.dm_byte;
            e_wd   = bus.dm_wdata;
            wd_chk = e_we;
        end else if (e_if) begin
            e_addr = bus.if_addr;
            wd_chk = 1'b0;
        end
        check("if_gnt", bus.if_gnt, e_if);
        check("dm_gnt", bus.dm_gnt, e_dm);
        check("if_valid", bus.if_valid, m_if_valid);
        check("dm_valid", bus.dm_valid, m_dm_valid);
        check("if_rdata", bus.if_rdata, m_if_rdata);
        check("dm_rdata", bus.dm_rdata, m_dm_rdata);
        check("busy", busy, m_rmw);
        check("mem_we", bus.mem_we, e_we);
        check("mem_addr", bus.mem_addr, e_addr);
        if (wd_chk) check("mem_wd", bus.mem_wd, e_wd);
        c_if_gnt <= e_if;
        c_dm_gnt <= e_dm;
    end

    task automatic dm_txn(input logic we, input logic byt, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, output int waits);
        logic granted = 1'b0;
        bus.dm_req = 1'b1; bus.dm_we = we; bus.dm_byte = byt;
        bus.dm_addr = addr; bus.dm_wdata = wdata;
        waits = 0;
        for (int i = 0; i < 50 && !granted; i++) begin
            @(negedge clk);
            if (bus.dm_gnt) granted = 1'b1;
            else begin waits++; @(posedge clk); #1; end
        end
        check("dm_gnt_wait", granted, 1'b1);
        @(posedge clk); #1;
        bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_byte = 1'b0;
        bus.dm_addr = '0; bus.dm_wdata = '0;
    endtask

    task automatic if_txn(input logic [AW-1:0] addr, output int waits);
        logic granted = 1'b0;
        bus.if_req = 1'b1; bus.if_addr = addr;
        waits = 0;
        for (int i = 0; i < 50 && !granted; i++) begin
            @(negedge clk);
            if (bus.if_gnt) granted = 1'b1;
            else begin waits++; @(posedge clk); #1; end
        end
        check("if_gnt_wait", granted, 1'b1);
        @(posedge clk); #1;
        bus.if_req = 1'b0; bus.if_addr = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int         w;
        logic [3:0] dm_log, if_log;
        for (int i = 0; i < WORDS; i++) begin
            env_mem[i] = 32'hC0DE0000 | i;
            m_mem[i]   = 32'hC0DE0000 | i;
        end
        env_mem[4] = 32'h11223344; m_mem[4] = 32'h11223344;
        env_mem[8] = 32'h11223344; m_mem[8] = 32'h11223344;

        // Reset with both requests raised: no grants, everything cleared.
        reset = 1'b1;
        bus.if_req = 1'b1; bus.if_addr = 12'h010;
        bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_byte = 1'b0;
        bus.dm_addr = 12'h004; bus.dm_wdata = 32'hFFFFFFFF;
        @(negedge clk);
        check("rst_if_gnt", bus.if_gnt, 1'b0);
        check("rst_dm_gnt", bus.dm_gnt, 1'b0);
        check("rst_mem_we", bus.mem_we, 1'b0);
        check("rst_mem_addr", bus.mem_addr, 12'h000);
        check("rst_mem_wd", bus.mem_wd, 32'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_valids", {bus.if_valid, bus.dm_valid}, 2'b00);
        check("rst_rdata", bus.if_rdata | bus.dm_rdata, 32'h0);
        bus.if_req = 1'b0; bus.dm_req = 1'b0; bus.dm_we = 1'b0;
        bus.dm_addr = '0; bus.dm_wdata = '0; bus.if_addr = '0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Contention: both requests held for 4 cycles.
        bus.if_req = 1'b1; bus.if_addr = 12'h040;
        bus.dm_req = 1'b1; bus.dm_addr = 12'h030;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            dm_log[i] = bus.dm_gnt;
            if_log[i] = bus.if_gnt;
            @(posedge clk); #1;
        end
        bus.if_req = 1'b0; bus.dm_req = 1'b0;
`ifdef MEM_ARB_RR_EN
        check("contend_dm_gnts", dm_log, 4'b0101);
        check("contend_if_gnts", if_log, 4'b1010);
`else
        check("contend_dm_gnts", dm_log, 4'b1111);
        check("contend_if_gnts", if_log, 4'b0000);
`endif
        @(posedge clk); #1;

        // Single fetch.
        if_txn(12'h010, w);
        check("fetch_wait", w, 0);
        @(negedge clk);
        check("fetch_valid", bus.if_valid, 1'b1);
        check("fetch_rdata", bus.if_rdata, 32'h11223344);
        @(posedge clk); #1;

        // Word store then back-to-back load.
        dm_txn(1'b1, 1'b0, 12'h004, 32'hDEADBEEF, w);
        dm_txn(1'b0, 1'b0, 12'h004, 32'h0, w);
        check("load_b2b_wait", w, 0);
        @(negedge clk);
        check("load_valid", bus.dm_valid, 1'b1);
        check("load_rdata", bus.dm_rdata, 32'hDEADBEEF);
        @(posedge clk); #1;

        // Byte store into 0x11223344, then read it back.
        dm_txn(1'b1, 1'b1, 12'h020, 32'h000000AB, w);
        @(negedge clk);
        check("bs_busy", busy, 1'b1);
        check("bs_mem_we", bus.mem_we, 1'b1);
        check("bs_mem_wd", bus.mem_wd, 32'h112233AB);
        @(posedge clk); #1;
        dm_txn(1'b0, 1'b0, 12'h020, 32'h0, w);
        @(negedge clk);
        check("bs_readback", bus.dm_rdata, 32'h112233AB);
        @(posedge clk); #1;

        // Fetch raised during the RMW cycle waits one cycle.
        dm_txn(1'b1, 1'b1, 12'h024, 32'h00000055, w);
        bus.if_req = 1'b1; bus.if_addr = 12'h010;
        @(negedge clk);
        check("rmw_if_gnt_low", bus.if_gnt, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        check("post_rmw_if_gnt", bus.if_gnt, 1'b1);
        @(posedge clk); #1;
        bus.if_req = 1'b0; bus.if_addr = '0;
        @(negedge clk);
        check("post_rmw_if_valid", bus.if_valid, 1'b1);
        check("post_rmw_if_rdata", bus.if_rdata, 32'h11223344);
        @(posedge clk); #1;
        check("rmw_word9", env_mem[9], 32'hC0DE0055);

        // Reset asserted in the RMW cycle suppresses the write.
        dm_txn(1'b1, 1'b1, 12'h008, 32'h000000AB, w);
        reset = 1'b1;
        @(negedge clk);
        check("rstrmw_mem_we", bus.mem_we, 1'b0);
        check("rstrmw_busy", busy, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("rstrmw_dm_valid", bus.dm_valid, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rstrmw_word2", env_mem[2], 32'hC0DE0002);
        check("final_word1", env_mem[1], 32'hDEADBEEF);
        check("final_word8", env_mem[8], 32'h112233AB);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Single-port arbiter and sequencer for the byte-addressable, little-endian unified memory (combinational read, clocked write). It shares one memory port between the instruction-fetch requester and the data-memory requester. It turns each granted request into a one-cycle-latency response and executes byte stores as a two-cycle read-modify-write. It sits between the pipeline's fetch/memory stages and the memory instance.

## Interface
- ADDR_WIDTH, 12, memory byte-address width
- BYTE_SIZE, 4, bytes per memory word; data width is 8*BYTE_SIZE

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- if_req  in  1  fetch read request
- if_addr  in  ADDR_WIDTH  fetch byte address
- if_gnt  out  1  fetch request accepted this cycle (combinational)
- if_valid  out  1  fetch read data valid (registered pulse)
- if_rdata  out  8*BYTE_SIZE  fetch read data
- dm_req  in  1  data request
- dm_we  in  1  1 = store, 0 = load
- dm_byte  in  1  store width: 1 = byte, 0 = full word
- dm_addr  in  ADDR_WIDTH  data byte address
- dm_wdata  in  8*BYTE_SIZE  store data; byte store uses [7:0]
- dm_gnt  out  1  data request accepted this cycle (combinational)
- dm_valid  out  1  data access complete / load data valid (registered pulse)
- dm_rdata  out  8*BYTE_SIZE  load data
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_WIDTH  memory byte address
- mem_wd  out  8*BYTE_SIZE  memory write data
- mem_rd  in  8*BYTE_SIZE  memory combinational read data
- busy  out  1  high while in RMW state

## Operation
- States:
  - IDLE: arbitrate and service word accesses.
  - RMW: second cycle of a byte store.
- Handshake:
  - A request is accepted on the rising edge where req and gnt are both high.
  - The requester holds req, address and data stable until gnt.
  - The requester may present a new request in the cycle following acceptance.
- Arbitration in IDLE:
  - At most one gnt per cycle.
  - No gnt in RMW.
- Granted word load or fetch:
  - mem_addr = requester address, mem_we = 0.
  - mem_rd is captured into that requester's rdata register at the edge.
  - valid pulses the next cycle.
- Granted word store:
  - mem_addr = dm_addr, mem_wd = dm_wdata, mem_we = 1 in the grant cycle.
  - dm_valid pulses the next cycle.
  - dm_rdata is unchanged.
- Granted byte store:
  - Grant cycle: mem_addr = dm_addr, mem_we = 0.
  - At the edge, capture mem_rd into a merge register and latch the address and byte.
  - Go to RMW.
  - RMW cycle: mem_addr = latched address, mem_wd = {merge[8*BYTE_SIZE-1:8], byte}, mem_we = 1.
  - At the edge, return to IDLE and pulse dm_valid the next cycle.
- Idle outputs: mem_addr = 0, mem_we = 0, mem_wd = 0.
- No alignment or range checks; addresses pass through unchanged.
- rdata registers hold their value until the next load or fetch for that requester.

## Timing
- Reset (asynchronous, immediate):
  - State = IDLE, round-robin pointer = data.
  - All valid, rdata and merge registers = 0.
  - busy = 0, gnt = 0.
  - mem_we = 0, mem_addr = 0, mem_wd = 0.
- Latency from accept to valid:
  - 1 cycle for load, fetch and word store.
  - 2 cycles for byte store.
- Throughput:
  - One word access per cycle, back-to-back.
  - Byte store occupies the port for 2 cycles.
- Simultaneous if_req and dm_req: resolved by arbitration policy (Configuration).
- The losing requester keeps req high and is granted later. Starvation-free only with round-robin.
- A request arriving during RMW waits, with gnt low, until the IDLE cycle after RMW.
- Reset asserted during RMW: write is suppressed, no dm_valid, state = IDLE.
- if_valid and dm_valid may be high in the same cycle only if issued on different edges. Each is a single-cycle pulse per accepted request.

## Configuration
- MEM_ARB_RR_EN defined:
  - Round-robin arbitration. The pointer flips to the other requester after every grant.
  - On conflict, the pointed-to requester wins.
- MEM_ARB_RR_EN undefined:
  - Fixed priority, data over fetch.
  - No pointer register.

## Structure
- Shared package holds:
  - the state enum (IDLE, RMW)
  - requester ID constants (REQ_IF = 0, REQ_DM = 1)
  - the default ADDR_WIDTH and BYTE_SIZE
- One sub-module, mem_arb_pick: the combinational grant selector (fixed or round-robin) taking both reqs and the pointer, producing both gnts.
- Top level holds:
  - the FSM
  - the response registers
  - the RMW merge path

## Test plan
- Reset mid-RMW: byte store 0xAB to addr 8, reset asserted in the RMW cycle -> mem_we never high, no dm_valid, memory word at 8 unchanged.
- Single fetch: mem word at 0x10 = 0x11223344, if_req with addr 0x10 -> if_gnt same cycle, if_valid next cycle, if_rdata = 0x11223344.
- Word store then load: store 0xDEADBEEF to addr 4, then load addr 4 back-to-back -> mem_we for 1 cycle, both dm_valid pulses on consecutive cycles, dm_rdata = 0xDEADBEEF.
- Byte store: word at 0x20 = 0x11223344, byte store dm_wdata = 0x000000AB -> busy 1 cycle, mem_wd = 0x112233AB, later load returns 0x112233AB.
- Contention:
  - Without the macro: if_req and dm_req held high for 4 cycles -> dm_gnt every cycle, if_gnt never.
  - With MEM_ARB_RR_EN: grants alternate data, fetch, data, fetch.
- Request during RMW: if_req raised in the RMW cycle of a byte store -> if_gnt low in RMW, high in the next IDLE cycle, if_valid one cycle later.
